prog_loader: RTL and testbench

Boot-time program loader sitting directly upstream of the CPU/memory pair. It accepts a framed byte stream over a valid/ready handshake and writes the payload into program memory through the same single-port write interface the CPU uses (enable, address, write data). It holds the CPU in reset until a frame has been written and its checksum verified, then releases it. It owns the memory port only while `cpu_run` is low; top-level muxing selects loader or CPU by `cpu_run`.

---
 rtl/prog_loader_pkg.sv | 16 +
 rtl/prog_loader_if.sv | 11 +
 rtl/prog_loader_timeout.sv | 31 +++
 rtl/prog_loader.sv | 126 ++++++++++++
 tb/tb_prog_loader.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared state type and frame limits for the program loader
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    SUM,
    DONE,
    ERR
  } loader_state_t;

  // LEN is a single byte, so a frame never carries more than this many payload bytes
  localparam int FRAME_MAX_LEN = 255;

endpackage

// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - byte stream handshake into the program loader
interface prog_loader_if;

  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/prog_loader_timeout.sv
// rtl/prog_loader_timeout.sv - idle-cycle watchdog for an in-progress frame
module loader_timeout #(
  parameter int TIMEOUT = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // Fires on the idle cycle that would bring the count to TIMEOUT, so the
  // loader leaves the frame on that same edge; an acceptance suppresses inc.
  assign expired = inc && (cnt == CW'(TIMEOUT - 1));

  // Idle-cycle counter, cleared on every accepted byte and outside a frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (inc && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - framed byte stream to program memory loader with CPU release
module prog_loader
  import loader_pkg::*;
#(
  parameter logic [7:0] BASE_ADR = 8'h00,
  parameter int         TIMEOUT  = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  prog_loader_if.slave      src,
  output logic              memEnable,
  output logic [7:0]        memAdr,
  output logic [7:0]        memWD,
  output logic              cpu_run,
  output logic              done,
  output logic              err,
  output logic [7:0]        byte_count
);

  localparam int LEN_W = $clog2(FRAME_MAX_LEN + 1);

  loader_state_t    state, next_state;
  logic [LEN_W-1:0] remaining;
  logic [7:0]       acc;
  logic [7:0]       ptr;
  logic             active;
  logic             accept;
  logic             expired;

  assign active = (state == LEN) || (state == DATA) || (state == SUM);
  assign accept = src.in_valid && src.in_ready;

  loader_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (accept || !active),
    .inc     (active && !accept),
    .expired (expired)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state: frame sequencing, checksum verdict and idle abort
  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE, ERR: begin
        if (start) next_state = LEN;
      end
      LEN: begin
        if (accept)       next_state = (src.in_data == 8'h00) ? ERR : DATA;
        else if (expired) next_state = ERR;
      end
      DATA: begin
        if (accept) begin
          if (remaining == LEN_W'(1)) next_state = SUM;
        end else if (expired) begin
          next_state = ERR;
        end
      end
      SUM: begin
        if (accept)       next_state = (src.in_data == acc) ? DONE : ERR;
        else if (expired) next_state = ERR;
      end
      default: next_state = IDLE;
    endcase
  end

  // Status outputs decoded from the state register only, never from in_valid
  always_comb begin
    src.in_ready = active;
    done         = (state == DONE);
    cpu_run      = (state == DONE);
    err          = (state == ERR);
  end

  // Datapath: length, checksum, address pointer and the one-cycle write strobe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      remaining  <= '0;
      acc        <= '0;
      ptr        <= BASE_ADR;
      byte_count <= '0;
      memEnable  <= 1'b0;
      memAdr     <= BASE_ADR;
      memWD      <= '0;
    end else begin
      memEnable <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            acc        <= '0;
            byte_count <= '0;
          end
        end
        LEN: begin
          if (accept) begin
            remaining <= LEN_W'(src.in_data);
            ptr       <= BASE_ADR;
          end
        end
        DATA: begin
          if (accept) begin
            acc        <= acc + src.in_data;
            memEnable  <= 1'b1;
            memAdr     <= ptr;
            memWD      <= src.in_data;
            ptr        <= ptr + 8'd1;
            byte_count <= byte_count + 8'd1;
            remaining  <= remaining - LEN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - randomized scoreboard bench for prog_loader
module tb_prog_loader;

  localparam int         T      = 8;
  localparam logic [7:0] BASE_A = 8'h00;
  localparam logic [7:0] BASE_B = 8'hFE;

  logic       clk      = 1'b0;
  logic       reset    = 1'b0;
  logic       start    = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data  = 8'h00;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  prog_loader_if ifa ();
  prog_loader_if ifb ();

  assign ifa.in_data  = in_data;
  assign ifa.in_valid = in_valid;
  assign ifb.in_data  = in_data;
  assign ifb.in_valid = in_valid;

  logic       me  [2];
  logic [7:0] ma  [2];
  logic [7:0] mw  [2];
  logic [7:0] bc  [2];
  logic       run [2];
  logic       dn  [2];
  logic       er  [2];
  logic       rdy [2];

  assign rdy[0] = ifa.in_ready;
  assign rdy[1] = ifb.in_ready;

  prog_loader #(.BASE_ADR(BASE_A), .TIMEOUT(T)) u_a (
    .clk(clk), .reset(reset), .start(start), .src(ifa),
    .memEnable(me[0]), .memAdr(ma[0]), .memWD(mw[0]),
    .cpu_run(run[0]), .done(dn[0]), .err(er[0]), .byte_count(bc[0])
  );

  prog_loader #(.BASE_ADR(BASE_B), .TIMEOUT(T)) u_b (
    .clk(clk), .reset(reset), .start(start), .src(ifb),
    .memEnable(me[1]), .memAdr(ma[1]), .memWD(mw[1]),
    .cpu_run(run[1]), .done(dn[1]), .err(er[1]), .byte_count(bc[1])
  );

  typedef struct {
    int         c;
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t        qa [$];
  wr_t        qb [$];
  logic [7:0] fst [$];
  int         fgp [$];
  int         stop_at = -1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected memory write for payload index idx, visible in the cycle after edge c
  task automatic push_wr(input int c, input int idx, input logic [7:0] d);
    wr_t        w;
    logic [7:0] off;
    off = idx[7:0];
    w.c = c; w.d = d;
    w.a = BASE_A + off;
    qa.push_back(w);
    w.a = BASE_B + off;
    qb.push_back(w);
  endtask

  // Monitor: every write strobe must match the oldest expected write and its cycle
  always @(negedge clk) begin
    if (reset) begin
      for (int u = 0; u < 2; u++) begin
        if (me[u]) begin
          wr_t w;
          int  have;
          have = (u == 0) ? qa.size() : qb.size();
          if (have == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_write[%0d]: got addr %0h data %0h, expected no write", u, ma[u], mw[u]);
          end else begin
            if (u == 0) w = qa.pop_front();
            else        w = qb.pop_front();
            chk($sformatf("wr_cycle[%0d]", u), cyc, w.c);
            chk($sformatf("wr_addr[%0d]", u), ma[u], w.a);
            chk($sformatf("wr_data[%0d]", u), mw[u], w.d);
          end
        end
      end
    end
  end

  task automatic chk_reset();
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("rst_in_ready[%0d]", u), rdy[u], 0);
      chk($sformatf("rst_memEnable[%0d]", u), me[u], 0);
      chk($sformatf("rst_memAdr[%0d]", u), ma[u], (u == 0) ? BASE_A : BASE_B);
      chk($sformatf("rst_memWD[%0d]", u), mw[u], 0);
      chk($sformatf("rst_cpu_run[%0d]", u), run[u], 0);
      chk($sformatf("rst_done[%0d]", u), dn[u], 0);
      chk($sformatf("rst_err[%0d]", u), er[u], 0);
      chk($sformatf("rst_byte_count[%0d]", u), bc[u], 0);
    end
  endtask

  task automatic end_check(input bit ok, input int paid);
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("end_done[%0d]", u), dn[u], ok);
      chk($sformatf("end_err[%0d]", u), er[u], !ok);
      chk($sformatf("end_cpu_run[%0d]", u), run[u], ok);
      chk($sformatf("end_byte_count[%0d]", u), bc[u], paid);
      chk($sformatf("end_in_ready[%0d]", u), rdy[u], 0);
    end
    chk("pending_writes_a", qa.size(), 0);
    chk("pending_writes_b", qb.size(), 0);
  endtask

  // Reference model: drives fst with per-byte idle gaps fgp and predicts the verdict
  task automatic send_frame();
    int n, sum, paid;
    n = fst[0]; sum = 0; paid = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("start_in_ready[%0d]", u), rdy[u], 1);
      chk($sformatf("start_cpu_run[%0d]", u), run[u], 0);
      chk($sformatf("start_done[%0d]", u), dn[u], 0);
      chk($sformatf("start_err[%0d]", u), er[u], 0);
      chk($sformatf("start_byte_count[%0d]", u), bc[u], 0);
    end
    for (int i = 0; i < fst.size(); i++) begin
      if (i == stop_at) return;
      in_valid = 1'b0;
      if (fgp[i] >= T) begin
        repeat (T) begin @(posedge clk); #1; end
        end_check(1'b0, paid);
        return;
      end
      repeat (fgp[i]) begin @(posedge clk); #1; end
      in_valid = 1'b1;
      in_data  = fst[i];
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (i >= 1 && i <= n) begin
        push_wr(cyc, paid, fst[i]);
        sum += int'(fst[i]);
        paid++;
      end
    end
    if (n == 0) end_check(1'b0, 0);
    else        end_check((sum % 256) == int'(fst[n + 1]), paid);
  endtask

  task automatic make_frame(input int n, input bit good, input int max_gap);
    int s, g, r;
    logic [7:0] b;
    s = 0;
    fst.delete();
    fgp.delete();
    fst.push_back(n[7:0]);
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      fst.push_back(b);
      s += int'(b);
    end
    if (n > 0) begin
      if (!good) s += $urandom_range(1, 255);
      fst.push_back(s[7:0]);
    end
    for (int i = 0; i < fst.size(); i++) begin
      r = $urandom % 10;
      if (max_gap == 0)      g = 0;
      else if (max_gap < T)  g = $urandom_range(0, max_gap);
      else if (r < 6)        g = 0;
      else if (r < 8)        g = $urandom_range(1, 3);
      else if (r == 8)       g = T - 1;
      else                   g = ($urandom % 3 == 0) ? T : 0;
      fgp.push_back(g);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_reset();
    reset = 1'b1;
    @(posedge clk); #1;

    fst = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
    fgp = '{0, 0, 0, 0, 0};
    send_frame();

    fst = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h67};
    send_frame();

    fst = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
    send_frame();

    fst = '{8'h00};
    fgp = '{0};
    send_frame();
    repeat (3) begin @(posedge clk); #1; end
    chk("len0_pending_a", qa.size(), 0);

    make_frame(4, 1'b1, 0);
    send_frame();

    make_frame(4, 1'b1, 0);
    fgp[3] = T;
    send_frame();

    make_frame(4, 1'b1, 0);
    fgp[3] = T - 1;
    send_frame();

    for (int f = 0; f < 30; f++) begin
      make_frame(($urandom % 8 == 0) ? 0 : $urandom_range(1, 20), ($urandom % 4) != 0, T);
      send_frame();
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end

    make_frame(12, 1'b1, 2);
    stop_at = $urandom_range(3, 10);
    send_frame();
    stop_at = -1;
    #2;
    reset = 1'b0;
    qa.delete();
    qb.delete();
    #1;
    chk_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;

    make_frame(6, 1'b1, 2);
    send_frame();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
